// File: rtl/ita_oup_drain_if.sv
// ita_oup_drain_if: FIFO-pop and output-beat channels of the ITA output drain.
// master (drain): fifo_ready_o, oup_valid_o, oup_data_o, oup_addr_o, oup_last_o out;
//                 fifo_valid_i, fifo_data_i, oup_ready_i in.
// slave (FIFO / streamer side): the mirror image.
interface ita_oup_drain_if #(
    parameter int unsigned N         = 16,
    parameter int unsigned WI        = 8,
    parameter int unsigned OutBytes  = 4,
    parameter int unsigned AddrWidth = 32
);
    logic                      fifo_valid_i;
    logic                      fifo_ready_o;
    logic [N*WI-1:0]           fifo_data_i;
    logic                      oup_valid_o;
    logic                      oup_ready_i;
    logic [OutBytes*WI-1:0]    oup_data_o;
    logic [AddrWidth-1:0]      oup_addr_o;
    logic                      oup_last_o;
    modport master (
        input  fifo_valid_i, fifo_data_i, oup_ready_i,
        output fifo_ready_o, oup_valid_o, oup_data_o, oup_addr_o, oup_last_o
    );
    modport slave (
        output fifo_valid_i, fifo_data_i, oup_ready_i,
        input  fifo_ready_o, oup_valid_o, oup_data_o, oup_addr_o, oup_last_o
    );
endinterface

// File: rtl/ita_oup_drain.sv
// ita_oup_drain: pops N*WI-bit FIFO words and serializes them into addressed OutBytes-byte beats.
// Ports: clk_i, rst_ni (async active-low); start_i, rows_i, cols_i, base_addr_i, row_stride_i job config;
// bus (ita_oup_drain_if.master) FIFO pop + output beat channels; busy_o, done_o status; perf_stall_o.
// Optional: define ITA_OUP_DRAIN_PERF_EN to build the saturating output-stall counter on perf_stall_o.
module ita_oup_drain #(
    parameter int unsigned N         = 16,
    parameter int unsigned WI        = 8,
    parameter int unsigned OutBytes  = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DimWidth  = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DimWidth-1:0]  rows_i,
    input  logic [DimWidth-1:0]  cols_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] row_stride_i,
    ita_oup_drain_if.master      bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          perf_stall_o
);
    localparam int unsigned BPW   = N / OutBytes;
    localparam int unsigned BeatW = OutBytes * WI;
    localparam int unsigned BW    = BPW > 1 ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

    state_e               state_q, state_d;
    logic [DimWidth-1:0]  rows_q, cols_q, row_q, col_q, cols_eff;
    logic [AddrWidth-1:0] row_base_q, stride_q;
    logic [BW-1:0]        beat_q;
    logic [N*WI-1:0]      hold_q;
    logic                 fire, pop, word_end, row_end, job_end;

    assign cols_eff = cols_i & ~DimWidth'(N - 1);
    assign fire     = bus.oup_valid_o && bus.oup_ready_i;
    assign pop      = bus.fifo_ready_o && bus.fifo_valid_i;
    assign word_end = beat_q == BW'(BPW - 1);
    assign row_end  = col_q == cols_q - DimWidth'(OutBytes);
    // Rows hold a whole number of words, so the job's last beat is also the last beat of its last word.
    assign job_end  = row_end && row_q == rows_q - DimWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !start_i ? IDLE : (rows_i == '0 || cols_eff == '0) ? DONE : FETCH;
            FETCH:   state_d = bus.fifo_valid_i ? SEND : FETCH;
            SEND:    state_d = !(fire && word_end) ? SEND : job_end ? DONE : bus.fifo_valid_i ? SEND : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // fifo_ready_o looks at oup_ready_i so the next word lands in hold_q without a bubble.
    always_comb begin
        bus.fifo_ready_o = state_q == FETCH || (state_q == SEND && bus.oup_ready_i && word_end && !job_end);
        bus.oup_valid_o  = state_q == SEND;
        bus.oup_last_o   = state_q == SEND && job_end;
        bus.oup_data_o   = hold_q[beat_q*BeatW +: BeatW];
        bus.oup_addr_o   = row_base_q + AddrWidth'(col_q);
        busy_o           = state_q != IDLE;
        done_o           = state_q == DONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            stride_q   <= '0;
            beat_q     <= '0;
            hold_q     <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                rows_q     <= rows_i;
                cols_q     <= cols_eff;
                row_base_q <= base_addr_i;
                stride_q   <= row_stride_i;
                row_q      <= '0;
                col_q      <= '0;
                beat_q     <= '0;
            end
            if (pop) begin
                hold_q <= bus.fifo_data_i;
                beat_q <= '0;
            end else if (fire) begin
                beat_q <= word_end ? '0 : beat_q + BW'(1);
            end
            if (fire) begin
                col_q      <= row_end ? '0 : col_q + DimWidth'(OutBytes);
                row_q      <= row_end ? row_q + DimWidth'(1) : row_q;
                row_base_q <= row_end ? row_base_q + stride_q : row_base_q;
            end
        end
    end

`ifdef ITA_OUP_DRAIN_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                                  stall_q <= '0;
        else if (state_q == IDLE && start_i)                          stall_q <= '0;
        else if (bus.oup_valid_o && !bus.oup_ready_i && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign perf_stall_o = stall_q;
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ita_oup_drain.sv
// tb_ita_oup_drain: directed self-checking bench for ita_oup_drain (N=16, OutBytes=4).
module tb_ita_oup_drain;
    logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
    logic [11:0] rows_i = '0, cols_i = '0;
    logic [31:0] base_addr_i = '0, row_stride_i = '0;
    logic        busy_o, done_o;
    logic [31:0] perf_stall_o;

    ita_oup_drain_if #(.N(16), .WI(8), .OutBytes(4), .AddrWidth(32)) bus ();

    ita_oup_drain #(.N(16), .WI(8), .OutBytes(4), .AddrWidth(32), .DimWidth(12)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
        .base_addr_i(base_addr_i), .row_stride_i(row_stride_i), .bus(bus),
        .busy_o(busy_o), .done_o(done_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0, n_err = 0, cyc = 0;
    int          widx = 0, wbase = 0, nwords = 4, starve = 0;
    bit          starve_en = 0, bp_en = 0, pop_now = 0;
    logic        rdy = 1'b1;
    logic [31:0] q_addr[$], q_data[$];
    logic        q_last[$];
    int          first_cyc, last_cyc, done_cyc, start_cyc, gaps, dones, stalls;
    bit          prev_stall = 0;
    logic [31:0] p_addr, p_data;
    logic        p_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(input int w);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(w * 16 + i);
        return r;
    endfunction

    assign bus.fifo_data_i  = mk_word(widx - wbase);
    assign bus.fifo_valid_i = (widx - wbase < nwords) && starve == 0;
    assign bus.oup_ready_i  = rdy;

    always @(posedge clk_i) begin
        rdy <= !bp_en || (cyc % 4 == 0) || (cyc % 4 == 3);
        if (pop_now) begin
            widx   <= widx + 1;
            starve <= starve_en ? 5 : 0;
        end else if (starve != 0) begin
            starve <= starve - 1;
        end
    end

    always @(negedge clk_i) begin
        if (!rst_ni) prev_stall = 0;
        if (prev_stall) begin
            check("stall_valid", bus.oup_valid_o, 1);
            check("stall_addr", bus.oup_addr_o, p_addr);
            check("stall_data", bus.oup_data_o, p_data);
            check("stall_last", bus.oup_last_o, p_last);
        end
        if (bus.oup_valid_o && bus.oup_ready_i) begin
            q_addr.push_back(bus.oup_addr_o);
            q_data.push_back(bus.oup_data_o);
            q_last.push_back(bus.oup_last_o);
            if (q_addr.size() == 1) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (bus.oup_valid_o && !bus.oup_ready_i) stalls++;
        if (busy_o && !bus.oup_valid_o && !done_o) gaps++;
        if (done_o) begin
            dones++;
            done_cyc = cyc;
        end
        prev_stall = rst_ni && bus.oup_valid_o && !bus.oup_ready_i;
        p_addr     = bus.oup_addr_o;
        p_data     = bus.oup_data_o;
        p_last     = bus.oup_last_o;
        pop_now    = bus.fifo_ready_o && bus.fifo_valid_i;
        cyc++;
    end

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_valid"}, bus.oup_valid_o, 0);
        check({tag, "_fready"}, bus.fifo_ready_o, 0);
        check({tag, "_last"}, bus.oup_last_o, 0);
        check({tag, "_addr"}, bus.oup_addr_o, 0);
        check({tag, "_data"}, bus.oup_data_o, 0);
        check({tag, "_perf"}, perf_stall_o, 0);
    endtask

    // Runs one job; poke pulses a stray start while busy, abort>0 resets once that many beats are accepted.
    task automatic run_job(input int r, input int c, input logic [31:0] b, input logic [31:0] s,
                           input int nw, input bit poke, input int abort);
        q_addr.delete();
        q_data.delete();
        q_last.delete();
        gaps   = 0;
        dones  = 0;
        stalls = 0;
        wbase  = widx;
        nwords = nw;
        @(posedge clk_i); #1;
        rows_i = 12'(r); cols_i = 12'(c); base_addr_i = b; row_stride_i = s; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i   = 1'b0;
        start_cyc = cyc;
        if (poke) begin
            repeat (3) @(posedge clk_i);
            #1 rows_i = 12'd0; start_i = 1'b1;
            @(posedge clk_i); #1 start_i = 1'b0; rows_i = 12'(r);
        end
        if (abort != 0) begin
            for (int i = 0; i < 200 && q_addr.size() < abort; i++) begin
                @(posedge clk_i); #1;
            end
            check("abort_beats", q_addr.size(), abort);
            rst_ni = 1'b0;
            #1 check_quiet("abort");
            repeat (2) @(posedge clk_i);
            #1 rst_ni = 1'b1;
            return;
        end
        for (int i = 0; i < 400 && dones == 0; i++) @(posedge clk_i);
        #1;
        if (dones == 0) check("timeout", 0, 1);
    endtask

    task automatic check_beats(input string tag, input int r, input int c, input logic [31:0] b, input logic [31:0] s);
        int          nb = r * c / 4;
        logic [31:0] ea, ed;
        check({tag, "_nbeats"}, q_addr.size(), nb);
        check({tag, "_pops"}, widx - wbase, nb / 4);
        for (int j = 0; j < nb && j < q_addr.size(); j++) begin
            ea = b + (j / (c / 4)) * s + (j % (c / 4)) * 4;
            for (int m = 0; m < 4; m++) ed[8*m +: 8] = 8'((j / 4) * 16 + (j % 4) * 4 + m);
            check($sformatf("%s_addr%0d", tag, j), q_addr[j], ea);
            check($sformatf("%s_data%0d", tag, j), q_data[j], ed);
            check($sformatf("%s_last%0d", tag, j), q_last[j], j == nb - 1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 check_quiet("reset");
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 check("idle_no_pop", widx, 0);

        run_job(2, 32, 32'h1000, 32'h40, 4, 0, 0);
        check_beats("basic", 2, 32, 32'h1000, 32'h40);
        if (q_data.size() == 16) begin
            check("lane_b0", q_data[0], 32'h03020100);
            check("lane_b3", q_data[3], 32'h0F0E0D0C);
            check("last_addr", q_addr[15], 32'h105C);
        end
        check("basic_gapless", last_cyc - first_cyc, 15);
        check("basic_fetch_gaps", gaps, 1);
        check("basic_done_time", done_cyc, last_cyc + 1);
        check("basic_done_once", dones, 1);
        check("basic_idle_busy", busy_o, 0);
        check("basic_perf", perf_stall_o, 0);

        bp_en = 1;
        run_job(2, 32, 32'h1000, 32'h40, 4, 0, 0);
        bp_en = 0;
        check_beats("bp", 2, 32, 32'h1000, 32'h40);
        check("bp_stalled", stalls > 0, 1);
        repeat (3) @(posedge clk_i);
        #1;
`ifdef ITA_OUP_DRAIN_PERF_EN
        check("bp_perf", perf_stall_o, stalls);
`else
        check("bp_perf", perf_stall_o, 0);
`endif

        starve_en = 1;
        run_job(2, 32, 32'h2000, 32'h80, 4, 1, 0);
        starve_en = 0;
        check_beats("starve", 2, 32, 32'h2000, 32'h80);
        check("starve_gaps", gaps, 7);
        check("starve_done_once", dones, 1);

        repeat (8) @(posedge clk_i);
        run_job(0, 32, 32'h3000, 32'h40, 4, 0, 0);
        check("rows0_beats", q_addr.size(), 0);
        check("rows0_pops", widx - wbase, 0);
        check("rows0_done_time", done_cyc, start_cyc);
        check("rows0_done_once", dones, 1);
        run_job(2, 8, 32'h3000, 32'h40, 4, 0, 0);
        check("cols8_beats", q_addr.size(), 0);
        check("cols8_pops", widx - wbase, 0);
        check("cols8_done_time", done_cyc, start_cyc);

        run_job(2, 32, 32'h1000, 32'h40, 4, 0, 5);
        check("abort_no_done", dones, 0);
        run_job(2, 32, 32'h1000, 32'h40, 4, 0, 0);
        check_beats("restart", 2, 32, 32'h1000, 32'h40);
        check("restart_done_once", dones, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
